// File: rtl/decryption_sched.sv
// rtl/decryption_sched.sv - routes ciphertext messages to one of three decryption engines
//
// Accepts a stream of characters, picks an engine from select_i on the first
// character of each message and forwards every character of that message to
// the chosen engine one cycle later. After the message ends (END_TOKEN or
// MAX_LEN characters) input is held off until the chosen engine has finished.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   data_i, valid_i     incoming ciphertext character and its strobe
//   select_i            engine choice (0 Caesar, 1 Scytale, 2 ZigZag, 3 invalid)
//   eng_busy_i[2:0]     per-engine "still emitting plaintext" flags
//   dataN_o, validN_o   registered character and strobe towards engine N
//   mux_select_o        engine whose output the downstream mux should take
//   busy_o              input is currently not accepted
//   msg_len_o           characters accepted in the current/last message
//   err_o               one-cycle protocol error pulse
module decryption_sched #(
    parameter int unsigned        D_WIDTH   = 8,
    parameter logic [D_WIDTH-1:0] END_TOKEN = D_WIDTH'(8'hFA),
    parameter int unsigned        MAX_LEN   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] data_i,
    input  logic               valid_i,
    input  logic [1:0]         select_i,
    input  logic [2:0]         eng_busy_i,
    output logic [D_WIDTH-1:0] data0_o,
    output logic [D_WIDTH-1:0] data1_o,
    output logic [D_WIDTH-1:0] data2_o,
    output logic               valid0_o,
    output logic               valid1_o,
    output logic               valid2_o,
    output logic [1:0]         mux_select_o,
    output logic               busy_o,
    output logic [7:0]         msg_len_o,
    output logic               err_o
);

    localparam logic [7:0] MAX_LEN_L = 8'(MAX_LEN);
    localparam logic [1:0] SEL_BAD   = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROUTE   = 2'd1,
        DISCARD = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [1:0]         mux_sel_q, mux_sel_d;
    logic [7:0]         len_q, len_d;
    logic               err_q, err_d;
    logic [2:0]         valid_q, valid_d;
    logic [D_WIDTH-1:0] data0_q, data0_d;
    logic [D_WIDTH-1:0] data1_q, data1_d;
    logic [D_WIDTH-1:0] data2_q, data2_d;

    logic               is_token;
    logic [7:0]         len_inc;
    logic               len_full;
    logic [3:0]         eng_busy_ext;
    logic               sel_eng_busy;
    logic               fwd_en;
    logic [1:0]         fwd_eng;

    assign is_token = (data_i == END_TOKEN);

    // Saturating count of the character being accepted this cycle.
    assign len_inc  = (len_q >= MAX_LEN_L) ? MAX_LEN_L : len_q + 8'd1;
    assign len_full = (len_inc == MAX_LEN_L);

    // Only the engine owning the message can hold the drain; the padding bit
    // keeps the index in range should sel_q ever read 3.
    assign eng_busy_ext = {1'b0, eng_busy_i};
    assign sel_eng_busy = eng_busy_ext[sel_q];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (select_i == SEL_BAD) begin
                        // A one-character bad message needs no discarding.
                        state_d = is_token ? IDLE : DISCARD;
                    end else begin
                        state_d = is_token ? DRAIN : ROUTE;
                    end
                end
            end
            ROUTE: begin
                if (valid_i && (is_token || len_full)) begin
                    state_d = DRAIN;
                end
            end
            DISCARD: begin
                if (valid_i && (is_token || len_full)) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                // Decided while already in DRAIN, so DRAIN lasts at least one cycle.
                if (!sel_eng_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == DRAIN);
    end

    // ----------------------------------------------------------- datapath
    always_comb begin
        sel_d     = sel_q;
        mux_sel_d = mux_sel_q;
        len_d     = len_q;
        err_d     = 1'b0;
        fwd_en    = 1'b0;
        fwd_eng   = sel_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    len_d = 8'd1;
                    if (select_i == SEL_BAD) begin
                        err_d = 1'b1;
                    end else begin
                        sel_d     = select_i;
                        mux_sel_d = select_i;
                        fwd_en    = 1'b1;
                        fwd_eng   = select_i;
                    end
                end
            end
            ROUTE: begin
                if (valid_i) begin
                    len_d  = len_inc;
                    fwd_en = 1'b1;
                    // Message cut short by the length limit rather than the token.
                    if (!is_token && len_full) begin
                        err_d = 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (valid_i) begin
                    len_d = len_inc;
                end
            end
            default: ;
        endcase
    end

    // Non-selected engines keep their last character on the data lines.
    always_comb begin
        valid_d = 3'b000;
        data0_d = data0_q;
        data1_d = data1_q;
        data2_d = data2_q;
        if (fwd_en) begin
            case (fwd_eng)
                2'd0: begin
                    valid_d[0] = 1'b1;
                    data0_d    = data_i;
                end
                2'd1: begin
                    valid_d[1] = 1'b1;
                    data1_d    = data_i;
                end
                2'd2: begin
                    valid_d[2] = 1'b1;
                    data2_d    = data_i;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q     <= 2'd0;
            mux_sel_q <= 2'd0;
            len_q     <= 8'd0;
            err_q     <= 1'b0;
            valid_q   <= 3'b000;
            data0_q   <= '0;
            data1_q   <= '0;
            data2_q   <= '0;
        end else begin
            sel_q     <= sel_d;
            mux_sel_q <= mux_sel_d;
            len_q     <= len_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
            data0_q   <= data0_d;
            data1_q   <= data1_d;
            data2_q   <= data2_d;
        end
    end

    assign data0_o      = data0_q;
    assign data1_o      = data1_q;
    assign data2_o      = data2_q;
    assign valid0_o     = valid_q[0];
    assign valid1_o     = valid_q[1];
    assign valid2_o     = valid_q[2];
    assign mux_select_o = mux_sel_q;
    assign msg_len_o    = len_q;
    assign err_o        = err_q;

endmodule

// File: doc/decryption_sched.md
DECRYPTION_SCHED -- requirements
Module: decryption_sched

Interface
REQ-001 Parameter D_WIDTH, default 8, character width in bits.
REQ-002 Parameter END_TOKEN, default 8'hFA, character that terminates a message.
REQ-003 Parameter MAX_LEN, default 64, maximum characters per message including END_TOKEN (2..255).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 data_i  input  D_WIDTH  incoming ciphertext character.
REQ-007 valid_i  input  1  data_i valid; accepted only when busy_o=0.
REQ-008 select_i  input  2  engine choice (0 Caesar, 1 Scytale, 2 ZigZag); sampled on the first accepted character of a message.
REQ-009 eng_busy_i  input  3  bit k high while engine k is still emitting plaintext.
REQ-010 data0_o/data1_o/data2_o  output  D_WIDTH each  character forwarded to engine 0/1/2.
REQ-011 valid0_o/valid1_o/valid2_o  output  1 each  forwarded-character strobe per engine.
REQ-012 mux_select_o  output  2  select driven to the output mux.
REQ-013 busy_o  output  1  high when input is not accepted.
REQ-014 msg_len_o  output  8  characters accepted in the current/last message.
REQ-015 err_o  output  1  one-cycle pulse on protocol error.

Function
REQ-016 States SHALL be IDLE, ROUTE, DISCARD, DRAIN.
REQ-017 IDLE: busy_o=0; on valid_i with select_i in 0..2, latch select into sel_q, set msg_len_o=1, forward the character, go ROUTE (or DRAIN if the character equals END_TOKEN).
REQ-018 IDLE: on valid_i with select_i=3, pulse err_o, set msg_len_o=1, forward nothing, go DISCARD (or stay IDLE if the character equals END_TOKEN).
REQ-019 Forwarding SHALL be registered: character accepted in cycle N appears on data{sel_q}_o with valid{sel_q}_o=1 in cycle N+1; other valid outputs 0.
REQ-020 data outputs of non-selected engines SHALL hold their previous values.
REQ-021 mux_select_o SHALL update to sel_q in the same cycle as the first forwarded valid and hold until the next message start.
REQ-022 ROUTE: busy_o=0; each accepted character is forwarded and increments msg_len_o; select_i is ignored.
REQ-023 ROUTE: accepted END_TOKEN is forwarded, then state goes DRAIN.
REQ-024 ROUTE: if msg_len_o reaches MAX_LEN on a non-token character, that character is forwarded, err_o pulses, state goes DRAIN.
REQ-025 DISCARD: busy_o=0; characters accepted, counted, not forwarded; END_TOKEN or MAX_LEN returns to IDLE.
REQ-026 DRAIN: busy_o=1; valid_i ignored; exit to IDLE in the first cycle where eng_busy_i[sel_q]=0, evaluated no earlier than the cycle after entry.
REQ-027 msg_len_o SHALL saturate at MAX_LEN and hold its value in IDLE until the next message start.
REQ-028 eng_busy_i bits of non-selected engines SHALL be ignored.
REQ-029 valid_i while busy_o=1 SHALL be dropped with no err_o.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, all valid outputs 0, data outputs 0, mux_select_o=0, busy_o=0, msg_len_o=0, err_o=0, sel_q=0.
REQ-031 Reset mid-message SHALL abort the message; no character accepted before reset is forwarded after it.

Verification
REQ-032 select_i=1, chars 41,42,FA on consecutive cycles -> valid1_o high cycles N+1..N+3 with 41,42,FA; mux_select_o=1 from N+1; busy_o=1 after FA until eng_busy_i[1] low; msg_len_o=3.
REQ-033 select_i=3, chars 10,FA -> err_o pulse at N+1, no valid*_o, back to IDLE, busy_o never high.
REQ-034 select_i=2, MAX_LEN=4, five non-token chars -> four forwarded on valid2_o, err_o pulse with the fourth, fifth dropped (busy_o=1), msg_len_o=4.
REQ-035 select_i changes 0->2 mid-message on engine 0 -> all characters stay on valid0_o, mux_select_o stays 0.
REQ-036 rst asserted in ROUTE after two chars -> outputs at reset values same cycle; next message with select_i=2 starts cleanly, msg_len_o=1.
REQ-037 DRAIN with eng_busy_i=3'b101, sel_q=1 -> exit to IDLE after one cycle despite bits 0 and 2 high.
